conv_fifo_ctrl: RTL

//  Packet-buffer controller and storage for the convertible FIFO. It sits directly upstream of the

---
 rtl/conv_fifo_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/conv_fifo_ctrl.sv
// conv_fifo_ctrl: packet buffer that receives one packet, lends it to the CPU, then streams it out.
// Optional DROP_OVERSIZE_EN discards oversize packets instead of truncating them.
module conv_fifo_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       in_data,
  input  logic [7:0]        in_ctrl,
  input  logic              in_wr,
  output logic              in_rdy,
  output logic [63:0]       out_data,
  output logic [7:0]        out_ctrl,
  output logic              out_wr,
  input  logic              out_rdy,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [63:0]       cpu_wdata,
  input  logic [7:0]        cpu_wctrl,
  input  logic              cpu_done,
  output logic              cpu_pkt_ready,
  output logic [63:0]       cpu_rdata,
  output logic [7:0]        cpu_rctrl,
  output logic [ADDR_W:0]   pkt_len,
  output logic              sel,
  output logic              pkt_ctrl,
  input  logic              cpu_pkt_ctrl_req,
  output logic              overflow
);
  typedef enum logic [1:0] {RX, PROC, TX} state_t;
  localparam logic [ADDR_W:0] ONE = 1;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, waddr, raddr;
  logic [ADDR_W:0] pkt_len_q, pkt_len_d;
  logic in_rdy_q, in_rdy_d, seen_q, seen_d, skip_q, skip_d, ovf_q, ovf_d;
  logic out_wr_q, pkt_ctrl_q;
  logic acc, eop, full, issue, last, we;
  logic [71:0] wdata, ram_q;
  logic [71:0] mem [0:2**ADDR_W-1];

  // seen_q marks that a payload word arrived, so a later nonzero ctrl ends the packet;
  // skip_q swallows the tail of a packet that hit the full boundary
  always_comb begin
    acc = state_q == RX && in_rdy_q && in_wr;
    eop = acc && in_ctrl != 8'h00 && seen_q;
    full = acc && !skip_q && !eop && &wr_ptr_q;
    issue = state_q == TX && out_rdy && {1'b0, rd_ptr_q} < pkt_len_q;
    last = issue && {1'b0, rd_ptr_q} + ONE == pkt_len_q;
    we = (acc && !skip_q) || (state_q == PROC && cpu_we);
    waddr = state_q == PROC ? cpu_addr : wr_ptr_q;
`ifdef DROP_OVERSIZE_EN
    wdata = state_q == PROC ? {cpu_wctrl, cpu_wdata} : {in_ctrl, in_data};
`else
    wdata = state_q == PROC ? {cpu_wctrl, cpu_wdata} : {full ? 8'h01 : in_ctrl, in_data};
`endif
    raddr = state_q == TX ? rd_ptr_q : cpu_addr;
    state_d = state_q;
    wr_ptr_d = acc && !skip_q ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = issue ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    pkt_len_d = pkt_len_q;
    in_rdy_d = state_q == RX;
    seen_d = seen_q || (acc && in_ctrl == 8'h00);
    skip_d = skip_q;
    ovf_d = ovf_q;
    if (eop) begin
      seen_d = 1'b0;
      if (skip_q) begin
        skip_d = 1'b0;
        wr_ptr_d = '0;
      end else begin
        pkt_len_d = {1'b0, wr_ptr_q} + ONE;
        in_rdy_d = 1'b0;
        state_d = PROC;
      end
    end
    if (full) begin
      skip_d = 1'b1;
`ifndef DROP_OVERSIZE_EN
      ovf_d = 1'b1;
      pkt_len_d = {1'b1, {ADDR_W{1'b0}}};
      in_rdy_d = 1'b0;
      state_d = PROC;
`endif
    end
    if (state_q == PROC && cpu_done) begin
      state_d = TX;
      rd_ptr_d = '0;
    end
    if (last) begin
      state_d = RX;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RX;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pkt_len_q <= '0;
      in_rdy_q <= 1'b1;
      seen_q <= 1'b0;
      skip_q <= 1'b0;
      ovf_q <= 1'b0;
      out_wr_q <= 1'b0;
      pkt_ctrl_q <= 1'b0;
      ram_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pkt_len_q <= pkt_len_d;
      in_rdy_q <= in_rdy_d;
      seen_q <= seen_d;
      skip_q <= skip_d;
      ovf_q <= ovf_d;
      out_wr_q <= issue;
      pkt_ctrl_q <= cpu_pkt_ctrl_req;
      ram_q <= mem[raddr];
    end
  end

  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;

  assign in_rdy = in_rdy_q;
  assign out_wr = out_wr_q;
  assign {out_ctrl, out_data} = ram_q;
  assign {cpu_rctrl, cpu_rdata} = ram_q;
  assign cpu_pkt_ready = state_q == PROC;
  assign sel = state_q == PROC;
  assign pkt_ctrl = state_q == PROC && pkt_ctrl_q;
  assign pkt_len = pkt_len_q;
  assign overflow = ovf_q;
endmodule
